// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM states, NOP encoding
// and the default reset PC.
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StFlush
    } fetch_state_e;

    localparam logic [31:0] NopInstr     = 32'h0000_0013;
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Fetch buffer: circular FIFO of instruction/PC pairs with push, pop, flush and
// occupancy output. Flush has priority over push and pop.
module if_fetch_fifo #(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [31:0]                  push_instr,
    input  logic [31:0]                  push_pc,
    input  logic                         pop,
    output logic [31:0]                  head_instr,
    output logic [31:0]                  head_pc,
    output logic [$clog2(Depth+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [31:0]     instr_mem [Depth];
    logic [31:0]     pc_mem    [Depth];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [CntW-1:0] cnt_q;

    // Storage carries no reset; the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_q] <= push_instr;
            pc_mem[wr_q]    <= push_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PtrW'(1);
            if (pop)  rd_q <= rd_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_instr = instr_mem[rd_q];
    assign head_pc    = pc_mem[rd_q];
    assign count      = cnt_q;
    assign empty      = (cnt_q == '0);

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues sequential fetches, buffers responses and
// handles redirects from EX with a one-cycle flush.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter int unsigned FB_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_instr,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready
);

    localparam int unsigned CntW = $clog2(FB_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            inflight_q;
    logic [31:0]     inflight_pc_q;
    logic            imem_req;

    logic [CntW-1:0] fb_count;
    logic            fb_empty;
    logic [31:0]     fb_instr, fb_pc;
    logic            fb_push, fb_pop;
    logic            bypass_valid, pop;
    logic [OccW-1:0] occ_next;
    logic            can_issue;

    // A response arriving into an empty buffer is presented directly; a redirect
    // discards it, so its validity never depends on the instruction data itself.
    assign bypass_valid = inflight_q && !i_redirect && fb_empty;
    assign o_valid      = !fb_empty || bypass_valid;
    assign pop          = o_valid && i_ready;
    assign fb_pop       = pop && !fb_empty;
    assign fb_push      = inflight_q && !i_redirect && !(bypass_valid && pop);

    assign occ_next  = OccW'(fb_count) + OccW'(inflight_q) - OccW'(pop);
    assign can_issue = occ_next < OccW'(FB_DEPTH);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        imem_req = 1'b0;
        unique case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: imem_req = can_issue;
            StFlush: state_d = StFetch;
            default: state_d = StBoot;
        endcase
        if (i_redirect) begin
            imem_req = 1'b0;
            state_d  = StFlush;
            pc_d     = align_pc(i_redirect_pc);
        end else if (imem_req) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= imem_req;
            if (imem_req) inflight_pc_q <= pc_q;
        end
    end

    if_fetch_fifo #(
        .Depth(FB_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_redirect),
        .push      (fb_push),
        .push_instr(i_imem_instr),
        .push_pc   (inflight_pc_q),
        .pop       (fb_pop),
        .head_instr(fb_instr),
        .head_pc   (fb_pc),
        .count     (fb_count),
        .empty     (fb_empty)
    );

    assign o_imem_req  = imem_req;
    assign o_imem_addr = pc_q;
    assign o_instr     = !fb_empty ? fb_instr : (bypass_valid ? i_imem_instr : NopInstr);
    assign o_pc        = !fb_empty ? fb_pc : (bypass_valid ? inflight_pc_q : RESET_PC);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: stimulus pushes expected transfers into a
// scoreboard queue, a negedge monitor pops and compares every decode handshake.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RstPc = 32'h0000_0000;
    localparam int unsigned Depth = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready = 1'b1;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .RESET_PC(RstPc),
        .FB_DEPTH(Depth)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_instr (imem_instr),
        .o_valid      (valid),
        .o_instr      (instr),
        .o_pc         (pc),
        .i_ready      (ready)
    );

    // Memory returns data one cycle after a request; garbage otherwise.
    int mem_mode = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a, input int m);
        return (m != 0) ? (a ^ 32'h1357_9BDF) : a;
    endfunction

    logic [31:0] mem_q = 32'hDEAD_BEEF;
    always @(posedge clk) mem_q <= imem_req ? mem_fn(imem_addr, mem_mode) : 32'hDEAD_BEEF;
    assign imem_instr = mem_q;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } xfer_t;

    xfer_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_pc(input logic [31:0] p, input int m);
        exp_q.push_back({p, mem_fn(p, m)});
    endtask

    always @(negedge clk) begin
        xfer_t e;
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                n_asserts++;
                n_fail++;
                $display("FAIL unexpected_xfer: got pc %h, required no transfer (t=%0t)", pc, $time);
            end else begin
                e = exp_q.pop_front();
                check("xfer_pc", pc, e.pc);
                check("xfer_instr", instr, e.instr);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        int nreq;
        nreq = 0;
        next(); next(); next();
        at_neg();
        check("rst_valid", valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, RstPc);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", pc, RstPc);

        // Sequential stream from reset, memory returns address as data.
        expect_pc(32'h0, 0); expect_pc(32'h4, 0); expect_pc(32'h8, 0); expect_pc(32'hC, 0);
        next(); rst_n = 1'b1;                           // c0 BOOT
        at_neg(); check("boot_req", imem_req, 0);
        next();                                         // c1 first issue
        at_neg(); check("c1_req", imem_req, 1); check("c1_addr", imem_addr, 32'h0);
        check("c1_valid", valid, 0);
        next();                                         // c2 first valid
        at_neg(); check("c2_valid", valid, 1); check("c2_pc", pc, 32'h0);
        next(); next(); next();                         // c3..c5

        // Redirect while fetch at 0x10 is in flight.
        expect_pc(32'h24, 0); expect_pc(32'h28, 0); expect_pc(32'h2C, 0);
        next(); redirect = 1'b1; redirect_pc = 32'h24;  // c6
        at_neg(); check("c6_valid", valid, 0); check("c6_req", imem_req, 0);
        next(); redirect = 1'b0;                        // c7 FLUSH
        at_neg(); check("c7_req", imem_req, 0); check("c7_valid", valid, 0);
        next();                                         // c8
        at_neg(); check("c8_req", imem_req, 1); check("c8_addr", imem_addr, 32'h24);
        next();                                         // c9
        at_neg(); check("c9_valid", valid, 1); check("c9_pc", pc, 32'h24);
        next(); next();                                 // c10, c11

        // Back-to-back redirects: only the second target survives.
        expect_pc(32'h80, 0); expect_pc(32'h84, 0); expect_pc(32'h88, 0);
        next(); redirect = 1'b1; redirect_pc = 32'h40;  // c12
        at_neg(); check("c12_valid", valid, 0);
        next(); redirect_pc = 32'h80;                   // c13
        at_neg(); check("c13_req", imem_req, 0);
        next(); redirect = 1'b0;                        // c14
        at_neg(); check("c14_req", imem_req, 0);
        next();                                         // c15
        at_neg(); check("c15_req", imem_req, 1); check("c15_addr", imem_addr, 32'h80);
        next(); next(); next();                         // c16..c18

        // Misaligned redirect target, new data pattern.
        expect_pc(32'h24, 1); expect_pc(32'h28, 1);
        next(); redirect = 1'b1; redirect_pc = 32'h27; mem_mode = 1;  // c19
        at_neg(); check("c19_valid", valid, 0);
        next(); redirect = 1'b0;                        // c20
        next();                                         // c21
        at_neg(); check("c21_req", imem_req, 1); check("c21_addr", imem_addr, 32'h24);
        next(); next();                                 // c22, c23

        // Stall fills the buffer, then redirect coincides with a pop of its head.
        expect_pc(32'h2C, 1); expect_pc(32'h100, 1); expect_pc(32'h104, 1);
        next(); ready = 1'b0;                           // c24
        at_neg(); check("c24_req", imem_req, 1); check("c24_addr", imem_addr, 32'h30);
        next();                                         // c25
        at_neg(); check("c25_req", imem_req, 0); check("c25_pc", pc, 32'h2C);
        next();                                         // c26
        at_neg(); check("c26_req", imem_req, 0);
        next(); ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;  // c27
        at_neg(); check("c27_valid", valid, 1);
        next(); redirect = 1'b0;                        // c28
        at_neg(); check("c28_valid", valid, 0);
        next(); next(); next();                         // c29..c31

        // PC wrap at the top of the address space, then reset mid-stream.
        expect_pc(32'hFFFF_FFF8, 1); expect_pc(32'hFFFF_FFFC, 1);
        expect_pc(32'h0, 1); expect_pc(32'h4, 1); expect_pc(32'h8, 1);
        next(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;  // c32
        next(); redirect = 1'b0;                        // c33
        next();                                         // c34
        at_neg(); check("c34_addr", imem_addr, 32'hFFFF_FFF8);
        next(); next();                                 // c36
        at_neg(); check("wrap_req", imem_req, 1); check("wrap_addr", imem_addr, 32'h0);
        next(); next();                                 // c37, c38
        next(); rst_n = 1'b0;                           // c39
        next(); redirect = 1'b1; redirect_pc = 32'h200; // c40 reset applied
        at_neg(); check("c40_valid", valid, 0); check("c40_req", imem_req, 0);
        check("c40_addr", imem_addr, RstPc);
        expect_pc(32'h0, 1); expect_pc(32'h4, 1);
        next(); rst_n = 1'b1; redirect = 1'b0;          // c41 BOOT
        at_neg(); check("c41_req", imem_req, 0);
        next();                                         // c42
        at_neg(); check("c42_req", imem_req, 1); check("c42_addr", imem_addr, RstPc);
        next(); next();                                 // c43, c44
        next(); rst_n = 1'b0; ready = 1'b0;             // c45
        next();

        // Decode stalled from reset release: exactly Depth fetches issued.
        expect_pc(32'h0, 1); expect_pc(32'h4, 1); expect_pc(32'h8, 1); expect_pc(32'hC, 1);
        next(); rst_n = 1'b1;                           // R BOOT
        for (int i = 0; i < 6; i++) begin
            at_neg();
            if (imem_req) nreq++;
            if (i != 5) next();
        end
        check("stall_fetches", nreq, Depth);
        check("stall_req_off", imem_req, 0);
        check("stall_head_pc", pc, 32'h0);
        next(); ready = 1'b1;                           // R+6
        next(); next(); next();                         // R+7..R+9
        next(); ready = 1'b0;                           // R+10
        next(); rst_n = 1'b0;
        next(); next();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
